// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg -- IF/ID pipeline register
//
// Captures the PC and instruction word fetched by IF and presents them to
// ID one cycle later. Hazard-unit stalls hold the register. Taken branches
// and jumps flush it with a bubble. A small state machine swallows the
// pre-boot fetch issued while the PC still holds its reset value, so ID
// never decodes a spurious first instruction.
//
// Parameters
//   WORD_BITWIDTH  width of PC and instruction (default 32)
//   NOP_INSTR      bubble encoding, addi x0,x0,0 (default 32'h00000013)
//   PC_RESET_VAL   value IF's PC holds during reset (default 32'hFFFFFFFC)
//
// Ports
//   clk               in   clock
//   rst               in   synchronous active-high reset
//   hz_IFIDWrite      in   1 = stall (hold register), same polarity as IF PC hold
//   PCSrc             in   1 = branch/jump taken in ID, current fetch is wrong-path
//   if_pc             in   PC presented by IF
//   if_instr          in   instruction-memory read data for if_pc
//   if_id_pc          out  registered PC (0 for bubbles)
//   if_id_instr       out  registered instruction (NOP_INSTR for bubbles)
//   if_id_valid       out  1 = if_id_instr is a real instruction
//   if_id_misaligned  out  registered |if_pc[1:0] at capture
//   stall_cnt         out  [IF_ID_PERF_CNT_EN only] stalled cycles outside boot
//   flush_cnt         out  [IF_ID_PERF_CNT_EN only] bubbles loaded due to PCSrc
//   dbg_state_o       out  current state encoding (S_BOOT/S_RUN/S_HOLD)
//
// Optional feature macro: IF_ID_PERF_CNT_EN adds the two wrapping 32-bit
// performance counters. Without it the counters and their ports are absent.
//
// Handshake: there is no backpressure from ID. if_id_valid qualifies the
// payload each cycle; a valid-1 output always carries a PC and instruction
// captured in the same cycle. Valid-0 outputs are bubbles whose pc field is
// 0 and must not be used for branch targets.
// ---------------------------------------------------------------------------
module if_id_reg #(
    parameter int                       WORD_BITWIDTH = 32,
    parameter logic [WORD_BITWIDTH-1:0] NOP_INSTR     = WORD_BITWIDTH'(32'h00000013),
    parameter logic [WORD_BITWIDTH-1:0] PC_RESET_VAL  = WORD_BITWIDTH'(32'hFFFFFFFC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hz_IFIDWrite,
    input  logic                     PCSrc,
    input  logic [WORD_BITWIDTH-1:0] if_pc,
    input  logic [WORD_BITWIDTH-1:0] if_instr,
    output logic [WORD_BITWIDTH-1:0] if_id_pc,
    output logic [WORD_BITWIDTH-1:0] if_id_instr,
    output logic                     if_id_valid,
    output logic                     if_id_misaligned,
`ifdef IF_ID_PERF_CNT_EN
    output logic [31:0]              stall_cnt,
    output logic [31:0]              flush_cnt,
`endif
    output logic [1:0]               dbg_state_o
);

    typedef enum logic [1:0] {
        S_BOOT = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10
    } state_e;

    state_e                   state_q, state_d;
    logic [WORD_BITWIDTH-1:0] pc_q, pc_d;
    logic [WORD_BITWIDTH-1:0] instr_q, instr_d;
    logic                     valid_q, valid_d;
    logic                     mis_q, mis_d;

    // Event strobes used only by the optional counters; kept unconditional so
    // the next-state logic reads the same in both builds.
    logic                     stall_evt;
    logic                     flush_evt;

    // -----------------------------------------------------------------------
    // Next-state and next-payload logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        mis_d     = mis_q;
        stall_evt = 1'b0;
        flush_evt = 1'b0;

        unique case (state_q)
            S_BOOT: begin
                // First cycle after reset: whatever IF shows is the pre-boot
                // fetch, so insert a bubble unconditionally.
                pc_d    = '0;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                mis_d   = 1'b0;
                state_d = S_RUN;
            end

            S_RUN, S_HOLD: begin
                if (hz_IFIDWrite) begin
                    // Stall wins over flush so this stage stays in lockstep
                    // with IF, which also holds its PC in that case.
                    stall_evt = 1'b1;
                    state_d   = S_HOLD;
                end else begin
                    state_d = S_RUN;
                    if (PCSrc) begin
                        flush_evt = 1'b1;
                        pc_d      = '0;
                        instr_d   = NOP_INSTR;
                        valid_d   = 1'b0;
                        mis_d     = 1'b0;
                    end else if (if_pc == PC_RESET_VAL) begin
                        // Boot guard: a fetch at the reset PC is never a real
                        // instruction (covers long reset-release skew in IF).
                        pc_d    = '0;
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                        mis_d   = 1'b0;
                    end else begin
                        pc_d    = if_pc;
                        instr_d = if_instr;
                        valid_d = 1'b1;
                        mis_d   = |if_pc[1:0];
                    end
                end
            end

            default: begin
                // Unreachable encoding: recover through boot with a bubble.
                pc_d    = '0;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                mis_d   = 1'b0;
                state_d = S_BOOT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and payload registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BOOT;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

    assign if_id_pc         = pc_q;
    assign if_id_instr      = instr_q;
    assign if_id_valid      = valid_q;
    assign if_id_misaligned = mis_q;
    assign dbg_state_o      = state_q;

`ifdef IF_ID_PERF_CNT_EN
    // -----------------------------------------------------------------------
    // Performance counters (wrap modulo 2^32)
    // -----------------------------------------------------------------------
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_evt) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // Strobes have no consumer in this build.
    logic unused_evt;
    assign unused_evt = stall_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// ---------------------------------------------------------------------------
// tb_if_id_reg -- self-checking bench for if_id_reg
//
// Directed walk through reset/boot, streaming, stall, flush, stall+flush,
// misaligned capture and mid-stall reset, followed by randomized traffic.
// Every cycle the DUT outputs are compared with a behavioural reference
// model that applies the register's rules directly to the inputs.
// ---------------------------------------------------------------------------
module tb_if_id_reg;

    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] RSTPC = 32'hFFFFFFFC;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        hz;
    logic        pcsrc;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic        o_valid;
    logic        o_mis;
    logic [1:0]  o_state;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] o_stall_cnt;
    logic [31:0] o_flush_cnt;
`endif

    always #5 clk = ~clk;

    if_id_reg dut (
        .clk              (clk),
        .rst              (rst),
        .hz_IFIDWrite     (hz),
        .PCSrc            (pcsrc),
        .if_pc            (if_pc),
        .if_instr         (if_instr),
        .if_id_pc         (o_pc),
        .if_id_instr      (o_instr),
        .if_id_valid      (o_valid),
        .if_id_misaligned (o_mis),
`ifdef IF_ID_PERF_CNT_EN
        .stall_cnt        (o_stall_cnt),
        .flush_cnt        (o_flush_cnt),
`endif
        .dbg_state_o      (o_state)
    );

    // ---------------- reference model ----------------
    // booting: the next edge is the first one after reset released.
    logic [31:0] m_pc, m_instr;
    logic        m_valid, m_mis, m_booting;
    logic [31:0] m_stall, m_flush;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_bubble();
        m_pc    = 32'h0;
        m_instr = NOP;
        m_valid = 1'b0;
        m_mis   = 1'b0;
    endtask

    // Apply one clock edge's worth of rules to the model.
    task automatic model_edge();
        if (rst) begin
            model_bubble();
            m_booting = 1'b1;
            m_stall   = 32'h0;
            m_flush   = 32'h0;
        end else if (m_booting) begin
            model_bubble();
            m_booting = 1'b0;
        end else if (hz) begin
            m_stall = m_stall + 32'd1;   // outputs held
        end else if (pcsrc) begin
            model_bubble();
            m_flush = m_flush + 32'd1;
        end else if (if_pc == RSTPC) begin
            model_bubble();
        end else begin
            m_pc    = if_pc;
            m_instr = if_instr;
            m_valid = 1'b1;
            m_mis   = (if_pc % 4) != 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic h, input logic p,
                         input logic [31:0] pc, input logic [31:0] ins);
        rst      = r;
        hz       = h;
        pcsrc    = p;
        if_pc    = pc;
        if_instr = ins;
    endtask

    // Clock edge, update model, then compare after outputs settle.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("pc",    o_pc,           m_pc);
        check("instr", o_instr,        m_instr);
        check("valid", 32'(o_valid),   32'(m_valid));
        check("mis",   32'(o_mis),     32'(m_mis));
`ifdef IF_ID_PERF_CNT_EN
        check("stall_cnt", o_stall_cnt, m_stall);
        check("flush_cnt", o_flush_cnt, m_flush);
`endif
    endtask

    task automatic step(input logic r, input logic h, input logic p,
                        input logic [31:0] pc, input logic [31:0] ins);
        drive(r, h, p, pc, ins);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m_booting = 1'b1;
        model_bubble();
        m_stall = 32'h0;
        m_flush = 32'h0;
        drive(1'b1, 1'b0, 1'b0, RSTPC, 32'h0);

        // 1. reset and boot
        tick();
        tick();
        check("rst_valid", 32'(o_valid), 32'h0);
        check("rst_instr", o_instr, NOP);
        step(1'b0, 1'b0, 1'b0, RSTPC, 32'hDEADBEEF);
        check("boot_valid", 32'(o_valid), 32'h0);
        check("boot_instr", o_instr, NOP);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h00500093);
        check("first_pc",    o_pc, 32'h0);
        check("first_instr", o_instr, 32'h00500093);
        check("first_valid", 32'(o_valid), 32'h1);

        // 2. streaming
        step(1'b0, 1'b0, 1'b0, 32'h4, 32'h00100113);
        step(1'b0, 1'b0, 1'b0, 32'h8, 32'h00200193);
        check("stream_pc", o_pc, 32'h8);

        // 3. stall three cycles with changing instr at pc C
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'hC, 32'hA0000000 + 32'(i));
            check("stall_hold_pc", o_pc, 32'h8);
        end
        step(1'b0, 1'b0, 1'b0, 32'hC, 32'h00300213);
        check("release_pc",    o_pc, 32'hC);
        check("release_instr", o_instr, 32'h00300213);

        // 4. flush then branch target
        step(1'b0, 1'b0, 1'b1, 32'h10, 32'h11111111);
        check("flush_valid", 32'(o_valid), 32'h0);
        check("flush_pc",    o_pc, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h40, 32'h00400293);
        check("target_pc",    o_pc, 32'h40);
        check("target_valid", 32'(o_valid), 32'h1);

        // 5. stall+flush together, after a fresh reset so counters start at 0
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, RSTPC, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h20, 32'h00600313);
        step(1'b0, 1'b1, 1'b1, 32'h24, 32'h22222222);
        step(1'b0, 1'b1, 1'b1, 32'h24, 32'h33333333);
        check("sf_hold_pc", o_pc, 32'h20);
        step(1'b0, 1'b0, 1'b1, 32'h24, 32'h44444444);
        check("sf_bubble", 32'(o_valid), 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h80, 32'h00700393);
        check("sf_target_pc", o_pc, 32'h80);
`ifdef IF_ID_PERF_CNT_EN
        check("sf_stall_cnt", o_stall_cnt, 32'd2);
        check("sf_flush_cnt", o_flush_cnt, 32'd1);
`endif

        // 6. misaligned capture, then reset while holding
        step(1'b0, 1'b0, 1'b0, 32'h6, 32'h00800413);
        check("mis_flag",  32'(o_mis), 32'h1);
        check("mis_valid", 32'(o_valid), 32'h1);
        step(1'b0, 1'b1, 1'b0, 32'h8, 32'h55555555);
        step(1'b0, 1'b1, 1'b0, 32'h8, 32'h66666666);
        step(1'b1, 1'b1, 1'b0, 32'h8, 32'h77777777);
        check("midrst_pc",    o_pc, 32'h0);
        check("midrst_instr", o_instr, NOP);
        check("midrst_valid", 32'(o_valid), 32'h0);
        check("midrst_mis",   32'(o_mis), 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h8, 32'h88888888);
        check("midrst_boot_valid", 32'(o_valid), 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h8, 32'h00900493);
        check("midrst_load_pc", o_pc, 32'h8);

        // 7. randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic        r, h, p;
            logic [31:0] pc;
            r  = ($urandom_range(0, 99) < 3);
            h  = ($urandom_range(0, 99) < 25);
            p  = ($urandom_range(0, 99) < 20);
            pc = $urandom & 32'h0000FFFC;
            if ($urandom_range(0, 9) == 0) pc = pc | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) pc = RSTPC;
            step(r, h, p, pc, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
